// File: rtl/fm_ctrl_pkg.sv
// Shared widths, sweep-mode encodings and FSM state type for the FM sweep controller.
package fm_ctrl_pkg;

    localparam int FREQ_W  = 24;
    localparam int STEP_W  = 16;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_RSVD   = 2'd3
    } sweep_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/fm_sweep_ctrl_dwell_timer.sv
// Dwell counter: counts enabled cycles and ticks when the count reaches limit, then restarts at 0.
module dwell_timer
    import fm_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               tick
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    assign tick = en && (count_q == limit);

    always_comb begin
        count_d = count_q;
        if (clr || tick) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fm_sweep_ctrl.sv
// Sweep controller: steps the carrier tuning word between start and stop with a per-frequency dwell,
// in single, sawtooth or triangle mode, and gates the deviation word while a sweep runs.
module fm_sweep_ctrl
    import fm_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FREQ_W-1:0]  cfg_f_start,
    input  logic [FREQ_W-1:0]  cfg_f_stop,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        fd_in,
    output logic [FREQ_W-1:0]  fc,
    output logic [15:0]        fd,
    output logic               busy,
    output logic               done
);

    localparam int PAD_W = FREQ_W - STEP_W;

    sweep_state_e       state_q, state_d;
    logic [FREQ_W-1:0]  fc_q, fc_d;
    logic [15:0]        fd_q, fd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [FREQ_W-1:0]  f_start_q, f_start_d;
    logic [FREQ_W-1:0]  f_stop_q, f_stop_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    sweep_mode_e        mode_q, mode_d;

    logic               timer_clr;
    logic               timer_en;
    logic               tick;

    logic [STEP_W-1:0]  step_eff;
    logic [FREQ_W-1:0]  stop_eff;
    logic [FREQ_W:0]    up_sum;
    logic [FREQ_W:0]    down_floor;
    logic [FREQ_W-1:0]  up_next;
    logic [FREQ_W-1:0]  down_next;

    // An inverted or empty range collapses onto f_start; both directions clamp in 25-bit space.
    assign step_eff   = (step_q == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : step_q;
    assign stop_eff   = (f_stop_q > f_start_q) ? f_stop_q : f_start_q;
    assign up_sum     = {1'b0, fc_q} + {{(PAD_W+1){1'b0}}, step_eff};
    assign down_floor = {1'b0, f_start_q} + {{(PAD_W+1){1'b0}}, step_eff};
    assign up_next    = (up_sum > {1'b0, stop_eff}) ? stop_eff : up_sum[FREQ_W-1:0];
    assign down_next  = ({1'b0, fc_q} < down_floor) ? f_start_q
                                                    : fc_q - {{PAD_W{1'b0}}, step_eff};

    assign timer_en  = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign cfg_ready = (state_q == ST_IDLE);
    assign fc        = fc_q;
    assign fd        = fd_q;
    assign busy      = busy_q;
    assign done      = done_q;

    dwell_timer u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .limit (dwell_q),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        fc_d      = fc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        f_start_d = f_start_q;
        f_stop_d  = f_stop_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        mode_d    = mode_q;
        timer_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    f_start_d = cfg_f_start;
                    f_stop_d  = cfg_f_stop;
                    step_d    = cfg_step;
                    dwell_d   = cfg_dwell;
                    mode_d    = sweep_mode_e'(cfg_mode);
                end else if (start && !abort) begin
                    state_d   = ST_UP;
                    fc_d      = f_start_q;
                    busy_d    = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            ST_UP: begin
                if (tick) begin
                    if (fc_q == stop_eff) begin
                        case (mode_q)
                            MODE_SAW: fc_d = f_start_q;
                            MODE_TRI: state_d = ST_DOWN;
                            default: begin
                                state_d = ST_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        fc_d = up_next;
                    end
                end
            end
            ST_DOWN: begin
                if (tick) begin
                    if (fc_q == f_start_q) begin
                        state_d = ST_UP;
                    end else begin
                        fc_d = down_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            fc_d      = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            timer_clr = 1'b1;
        end

        fd_d = busy_d ? fd_in : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fc_q      <= '0;
            fd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            mode_q    <= MODE_SINGLE;
        end else begin
            state_q   <= state_d;
            fc_q      <= fc_d;
            fd_q      <= fd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            f_start_q <= f_start_d;
            f_stop_q  <= f_stop_d;
            step_q    <= step_d;
            dwell_q   <= dwell_d;
            mode_q    <= mode_d;
        end
    end

endmodule

// File: tb/tb_fm_sweep_ctrl.sv
// Directed bench for fm_sweep_ctrl: hand-computed tuning-word sequences for each sweep mode,
// clamping, abort, config acceptance rules and mid-sweep reset.
module tb_fm_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_f_start;
    logic [23:0] cfg_f_stop;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        start;
    logic        abort;
    logic [15:0] fd_in;
    logic [23:0] fc;
    logic [15:0] fd;
    logic        busy;
    logic        done;

    int vector_count;
    int fail_count;

    fm_sweep_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .abort       (abort),
        .fd_in       (fd_in),
        .fc          (fc),
        .fd          (fd),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Outputs are sampled and inputs changed 1ns after each rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [23:0] f_start, input logic [23:0] f_stop,
                                 input logic [15:0] step, input logic [15:0] dwell,
                                 input logic [1:0] mode);
        cfg_valid   = 1'b1;
        cfg_f_start = f_start;
        cfg_f_stop  = f_stop;
        cfg_step    = step;
        cfg_dwell   = dwell;
        cfg_mode    = mode;
        stepClock();
        cfg_valid   = 1'b0;
    endtask

    task automatic startSweep();
        start = 1'b1;
        stepClock();
        start = 1'b0;
    endtask

    task automatic abortSweep();
        abort = 1'b1;
        stepClock();
        abort = 1'b0;
    endtask

    initial begin
        logic [23:0] tri_exp [9];
        logic [23:0] saw_exp [5];
        tri_exp = '{24'd0, 24'd10, 24'd20, 24'd20, 24'd10, 24'd0, 24'd0, 24'd10, 24'd20};
        saw_exp = '{24'd0, 24'd10, 24'd20, 24'd0, 24'd10};

        vector_count = 0;
        fail_count   = 0;
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_f_start  = '0;
        cfg_f_stop   = '0;
        cfg_step     = '0;
        cfg_dwell    = '0;
        cfg_mode     = '0;
        start        = 1'b0;
        abort        = 1'b0;
        fd_in        = 16'h1234;

        stepClock();
        stepClock();
        checkOutput("reset_fc", 32'(fc), 32'h0);
        checkOutput("reset_fd", 32'(fd), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        stepClock();

        $display("[TB] single sweep 100..130 step 10 dwell 2");
        applyStimulus(24'd100, 24'd130, 16'd10, 16'd2, 2'd0);
        startSweep();
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("single_fc_%0d", i), 32'(fc), 32'(100 + 10 * (i / 3)));
            checkOutput($sformatf("single_busy_%0d", i), 32'(busy), 32'h1);
            checkOutput($sformatf("single_fd_%0d", i), 32'(fd), 32'h1234);
            stepClock();
        end
        checkOutput("single_done", 32'(done), 32'h1);
        checkOutput("single_done_busy", 32'(busy), 32'h0);
        checkOutput("single_done_fc", 32'(fc), 32'd130);
        checkOutput("single_done_fd", 32'(fd), 32'h0);
        stepClock();
        checkOutput("single_after_done", 32'(done), 32'h0);
        checkOutput("single_after_ready", 32'(cfg_ready), 32'h1);
        checkOutput("single_after_fc", 32'(fc), 32'd130);

        $display("[TB] clamp at top of range");
        applyStimulus(24'hFFFFF0, 24'hFFFFFF, 16'h20, 16'd0, 2'd0);
        startSweep();
        checkOutput("clamp_fc0", 32'(fc), 32'hFFFFF0);
        stepClock();
        checkOutput("clamp_fc1", 32'(fc), 32'hFFFFFF);
        checkOutput("clamp_busy1", 32'(busy), 32'h1);
        stepClock();
        checkOutput("clamp_done", 32'(done), 32'h1);
        checkOutput("clamp_fc_done", 32'(fc), 32'hFFFFFF);
        stepClock();

        $display("[TB] triangle 0..20 step 10");
        applyStimulus(24'd0, 24'd20, 16'd10, 16'd0, 2'd2);
        startSweep();
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("tri_fc_%0d", i), 32'(fc), 32'(tri_exp[i]));
            checkOutput($sformatf("tri_done_%0d", i), 32'(done), 32'h0);
            stepClock();
        end
        abortSweep();
        checkOutput("tri_abort_busy", 32'(busy), 32'h0);

        $display("[TB] sawtooth 0..20 step 10");
        applyStimulus(24'd0, 24'd20, 16'd10, 16'd0, 2'd1);
        startSweep();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("saw_fc_%0d", i), 32'(fc), 32'(saw_exp[i]));
            stepClock();
        end
        abortSweep();

        $display("[TB] abort at 110");
        applyStimulus(24'd100, 24'd130, 16'd10, 16'd2, 2'd0);
        startSweep();
        stepClock();
        stepClock();
        stepClock();
        checkOutput("abort_pre_fc", 32'(fc), 32'd110);
        abortSweep();
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_fc", 32'(fc), 32'h0);
        checkOutput("abort_fd", 32'(fd), 32'h0);
        checkOutput("abort_done", 32'(done), 32'h0);
        checkOutput("abort_ready", 32'(cfg_ready), 32'h1);
        stepClock();
        checkOutput("abort_idle_done", 32'(done), 32'h0);

        $display("[TB] config acceptance rules");
        startSweep();
        checkOutput("busy_ready", 32'(cfg_ready), 32'h0);
        cfg_valid   = 1'b1;
        cfg_f_start = 24'd500;
        cfg_f_stop  = 24'd520;
        cfg_step    = 16'd10;
        cfg_dwell   = 16'd0;
        cfg_mode    = 2'd0;
        stepClock();
        cfg_valid = 1'b0;
        abortSweep();
        startSweep();
        checkOutput("ignored_cfg_fc", 32'(fc), 32'd100);
        abortSweep();
        cfg_valid = 1'b1;
        start     = 1'b1;
        stepClock();
        cfg_valid = 1'b0;
        start     = 1'b0;
        checkOutput("cfg_start_busy", 32'(busy), 32'h0);
        checkOutput("cfg_start_fc", 32'(fc), 32'h0);
        stepClock();
        checkOutput("cfg_start_idle", 32'(busy), 32'h0);
        startSweep();
        checkOutput("new_cfg_fc0", 32'(fc), 32'd500);
        stepClock();
        checkOutput("new_cfg_fc1", 32'(fc), 32'd510);
        stepClock();
        checkOutput("new_cfg_fc2", 32'(fc), 32'd520);
        stepClock();
        checkOutput("new_cfg_done", 32'(done), 32'h1);
        stepClock();

        $display("[TB] inverted range");
        applyStimulus(24'd50, 24'd10, 16'd5, 16'd0, 2'd1);
        startSweep();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("inv_saw_fc_%0d", i), 32'(fc), 32'd50);
            checkOutput($sformatf("inv_saw_busy_%0d", i), 32'(busy), 32'h1);
            stepClock();
        end
        abortSweep();
        applyStimulus(24'd50, 24'd10, 16'd5, 16'd1, 2'd3);
        startSweep();
        checkOutput("inv_single_fc0", 32'(fc), 32'd50);
        stepClock();
        checkOutput("inv_single_fc1", 32'(fc), 32'd50);
        checkOutput("inv_single_nodone", 32'(done), 32'h0);
        stepClock();
        checkOutput("inv_single_done", 32'(done), 32'h1);
        stepClock();

        $display("[TB] reset mid-sweep");
        applyStimulus(24'd100, 24'd130, 16'd10, 16'd2, 2'd0);
        startSweep();
        stepClock();
        rst = 1'b1;
        abort = 1'b1;
        stepClock();
        rst = 1'b0;
        abort = 1'b0;
        checkOutput("rst_fc", 32'(fc), 32'h0);
        checkOutput("rst_fd", 32'(fd), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_ready", 32'(cfg_ready), 32'h1);
        startSweep();
        checkOutput("rst_cfg_fc", 32'(fc), 32'h0);
        checkOutput("rst_cfg_busy", 32'(busy), 32'h1);
        stepClock();
        checkOutput("rst_cfg_done", 32'(done), 32'h1);
        stepClock();

        $display("[TB] zero step treated as one");
        applyStimulus(24'd0, 24'd3, 16'd0, 16'd1, 2'd0);
        startSweep();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("step0_fc_%0d", i), 32'(fc), 32'(i / 2));
            stepClock();
        end
        checkOutput("step0_done", 32'(done), 32'h1);
        checkOutput("step0_fc_done", 32'(fc), 32'd3);
        stepClock();

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fm_sweep_ctrl.md
FM_SWEEP_CTRL -- requirements
Module: fm_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, ports named as follows.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration can be accepted
- cfg_f_start  in  24  sweep start tuning word
- cfg_f_stop  in  24  sweep stop tuning word
- cfg_step  in  16  tuning-word increment per step
- cfg_dwell  in  16  hold length; each frequency is held cfg_dwell+1 cycles
- cfg_mode  in  2  0=single, 1=sawtooth, 2=triangle, 3=reserved (treated as single)
- start  in  1  begin sweep (level sampled)
- abort  in  1  terminate sweep
- fd_in  in  16  requested deviation word
- fc  out  24  carrier tuning word to FM datapath
- fd  out  16  deviation word to FM datapath
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at single-sweep completion

Function
REQ-002 The block SHALL capture all cfg_* fields into internal registers when cfg_valid && cfg_ready on a clock edge.
REQ-003 cfg_ready SHALL be 1 only in IDLE; cfg_valid outside IDLE SHALL be ignored.
REQ-004 The FSM SHALL have states IDLE, UP, DOWN, DONE.
REQ-005 IDLE: start=1 and abort=0 SHALL move to UP; on that edge fc<=f_start, the dwell counter <=0, busy<=1.
REQ-006 start and cfg_valid in the same IDLE cycle: config SHALL be accepted and start ignored.
REQ-007 Dwell counter SHALL increment every cycle in UP/DOWN; when it equals dwell the step action SHALL occur and the counter SHALL return to 0.
REQ-008 UP step action: if fc==f_stop then single->DONE, sawtooth->fc<=f_start (stay UP), triangle->DOWN (fc unchanged); else fc<=min(fc+step, f_stop).
REQ-009 DOWN step action: if fc==f_start then ->UP (fc unchanged); else fc<=max(fc-step, f_start).
REQ-010 Step arithmetic SHALL be 25-bit unsigned (zero-extended step); clamping SHALL prevent any wrap past 2^24-1 or below 0.
REQ-011 A captured cfg_step of 0 SHALL be treated as 1.
REQ-012 If f_stop<=f_start, f_stop SHALL be treated as equal to f_start: single completes after one dwell, other modes hold f_start until abort.
REQ-013 DONE SHALL last one cycle: done=1, busy=0 on the following edge, then IDLE; fc SHALL hold its last value.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with busy=0, fc=0, no done pulse; abort has priority over all other inputs.
REQ-015 fd SHALL be registered fd_in while busy=1 and 0 otherwise (one-cycle latency).
REQ-016 Config registers SHALL be unchanged by sweeping or abort; a new start reuses the last accepted config.

Reset
REQ-017 On rst=1: state IDLE, fc=0, fd=0, busy=0, done=0, cfg_ready=1 after the edge, config registers 0 (f_start=f_stop=0, step=0, dwell=0, mode=single).
REQ-018 rst SHALL override abort, start and cfg_valid, including mid-sweep.

Structure
REQ-019 A shared package fm_ctrl_pkg SHALL hold FREQ_W=24, STEP_W=16, DWELL_W=16, the mode encodings and the state enum.
REQ-020 The dwell counter SHALL be a sub-module dwell_timer (inputs clk, rst, clr, en, limit; output tick); all other logic stays in fm_sweep_ctrl.
REQ-021 The block SHALL NOT instantiate the FM datapath; fc/fd connect to it at the parent level.

Verification
REQ-022 Single: f_start=100, f_stop=130, step=10, dwell=2, start -> fc 100,110,120,130 each 3 cycles, then done pulse, busy=0, fc stays 130.
REQ-023 Clamp: f_start=0xFFFFF0, f_stop=0xFFFFFF, step=0x20, dwell=0 -> fc 0xFFFFF0, 0xFFFFFF, then done; no wrap.
REQ-024 Triangle: start=0, stop=20, step=10, dwell=0 -> fc 0,10,20,20,10,0,0,10,... continuous, done never asserted.
REQ-025 Abort mid-sweep at fc=110 -> next cycle busy=0, fc=0, fd=0, done=0, cfg_ready=1.
REQ-026 cfg_valid with new f_start=500 during busy -> ignored; start+cfg_valid in IDLE -> config taken, no sweep; next start sweeps from 500.
REQ-027 rst asserted during UP -> all outputs at reset values after the edge; step=0 config -> fc advances by 1 per dwell.
